// File: rtl/scan_pkg.sv
// Shared types and default widths for the raster scan sequencer.
package scan_pkg;

  localparam int unsigned ROW_W_DEF = 4;
  localparam int unsigned COL_W_DEF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/scan_sequencer_if.sv
// Beat stream carrying one row/column index pair per valid/ready transfer.
interface scan_sequencer_if
  import scan_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned COL_W = COL_W_DEF
);

  logic             valid;
  logic             ready;
  logic             last;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  modport master (output valid, output last, output row_idx, output col_idx, input ready);
  modport slave  (input valid, input last, input row_idx, input col_idx, output ready);

endinterface

// File: rtl/idx_counter.sv
// Index counter that steps to bound-1 then wraps to zero; wrap flags the top index.
module idx_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] bound,
  output logic [W-1:0] idx,
  output logic         wrap
);

  logic [W-1:0] idx_q;

  // Full-width compare, so a bound of 2^W-1 tops out at 2^W-2.
  assign wrap = (idx_q == bound - W'(1));
  assign idx  = idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (en) begin
      idx_q <= wrap ? '0 : idx_q + W'(1);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Row-major 2-D raster scan: one (row, col) beat per accepted transfer, done pulse at the end.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned COL_W = COL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ROW_W-1:0]        num_rows,
  input  logic [COL_W-1:0]        num_cols,
  output logic                    busy,
  output logic                    done,
  scan_sequencer_if.master        beat
);

  state_e           state_q;
  logic [ROW_W-1:0] rows_q;
  logic [COL_W-1:0] cols_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             row_wrap;
  logic             col_wrap;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;
  logic             xfer;
  logic             final_beat;
  logic             clr;
  logic             row_en;
  logic             col_en;

  // abort wins over a coincident transfer.
  assign xfer       = (state_q == StScan) & valid_q & beat.ready & ~abort;
  assign final_beat = xfer & row_wrap & col_wrap;
  assign clr        = ((state_q == StIdle) & start) | ((state_q == StScan) & abort);
  // Final beat leaves both indices parked on their last value.
  assign col_en     = xfer & ~final_beat;
  assign row_en     = xfer & col_wrap & ~row_wrap;

  idx_counter #(.W(ROW_W)) u_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (row_en),
    .bound (rows_q),
    .idx   (row_idx),
    .wrap  (row_wrap)
  );

  idx_counter #(.W(COL_W)) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (col_en),
    .bound (cols_q),
    .idx   (col_idx),
    .wrap  (col_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rows_q  <= '0;
      cols_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rows_q <= num_rows;
            cols_q <= num_cols;
            busy_q <= 1'b1;
            if ((num_rows == '0) || (num_cols == '0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StScan;
              valid_q <= 1'b1;
            end
          end
        end
        StScan: begin
          if (abort) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (final_beat) begin
            state_q <= StDone;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign beat.valid   = valid_q;
  assign beat.row_idx = row_idx;
  assign beat.col_idx = col_idx;
  assign beat.last    = valid_q & row_wrap & col_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_scan_sequencer;

  localparam int unsigned RW = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic [CW-1:0] num_cols = '0;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  scan_sequencer_if #(.ROW_W(RW), .COL_W(CW)) beat ();

  scan_sequencer #(.ROW_W(RW), .COL_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .num_rows (num_rows),
    .num_cols (num_cols),
    .busy     (busy),
    .done     (done),
    .beat     (beat.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st;
    logic ab;
    int   rows;
    int   cols;
    logic rdy;
    logic e_busy;
    logic e_valid;
    int   e_row;
    int   e_col;
    logic e_last;
    logic e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ab, input int rows, input int cols,
                     input logic rdy, input logic eb, input logic ev, input int er,
                     input int ec, input logic el, input logic ed);
    vec_t v;
    v.st = st; v.ab = ab; v.rows = rows; v.cols = cols; v.rdy = rdy;
    v.e_busy = eb; v.e_valid = ev; v.e_row = er; v.e_col = ec; v.e_last = el; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic ev, input int er,
                         input int ec, input logic el, input logic ed);
    chk({tag, ".busy"},  int'(busy), int'(eb));
    chk({tag, ".valid"}, int'(beat.valid), int'(ev));
    chk({tag, ".row"},   int'(beat.row_idx), er);
    chk({tag, ".col"},   int'(beat.col_idx), ec);
    chk({tag, ".last"},  int'(beat.last), int'(el));
    chk({tag, ".done"},  int'(done), int'(ed));
  endtask

  task automatic drive(input logic st, input logic ab, input int rows, input int cols,
                       input logic rdy);
    start      = st;
    abort      = ab;
    num_rows   = RW'(rows);
    num_cols   = CW'(cols);
    beat.ready = rdy;
  endtask

  // Inputs change just after a negedge; outputs are sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    beat.ready = 1'b0;

    // Basic scan 2x3, ready tied high
    add(1, 0, 2, 3, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 1, 2, 1, 0);
    add(0, 0, 0, 0, 1,  1, 0, 1, 2, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 1, 2, 0, 0);
    // abort in IDLE does nothing
    add(0, 1, 0, 0, 1,  0, 0, 1, 2, 0, 0);
    // Zero bound, then a start during DONE is dropped
    add(1, 0, 3, 0, 1,  1, 0, 0, 0, 0, 1);
    add(1, 0, 2, 2, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Backpressure 1x4, ready 1,0,0,1,1,0,1
    add(1, 0, 1, 4, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1,  1, 0, 0, 3, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 0);

    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].ab, vecs[i].rows, vecs[i].cols, vecs[i].rdy);
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_busy, vecs[i].e_valid, vecs[i].e_row,
              vecs[i].e_col, vecs[i].e_last, vecs[i].e_done);
    end

    // Abort at beat (1,2) of a 4x4 scan
    drive(1, 0, 4, 4, 1);
    step();
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) step();
    chk_all("ab_pre", 1, 1, 1, 2, 0, 0);
    drive(0, 1, 0, 0, 1);
    step();
    chk_all("ab_idle", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    step();
    chk_all("ab_nodone", 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 1);
    step();
    chk_all("one_beat", 1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    step();
    chk_all("one_done", 1, 0, 0, 0, 0, 1);
    step();
    chk_all("one_idle", 0, 0, 0, 0, 0, 0);

    // Start mid-scan with other bounds must not disturb a 2x2 scan
    drive(1, 0, 2, 2, 1);
    step();
    chk_all("ig0", 1, 1, 0, 0, 0, 0);
    drive(1, 0, 3, 3, 1);
    step();
    chk_all("ig1", 1, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    step();
    chk_all("ig2", 1, 1, 1, 0, 0, 0);
    step();
    chk_all("ig3", 1, 1, 1, 1, 1, 0);
    step();
    chk_all("ig_done", 1, 0, 1, 1, 0, 1);
    step();

    // Asynchronous reset in the middle of a cycle during SCAN
    drive(1, 0, 4, 4, 1);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    step();
    chk_all("ar_pre", 1, 1, 0, 2, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk_all("ar_now", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_all("ar_idle", 0, 0, 0, 0, 0, 0);

    // Max bounds 15x15: 225 beats, row-major, never reaching index 15
    drive(1, 0, 15, 15, 1);
    step();
    drive(0, 0, 0, 0, 1);
    for (int b = 0; b < 225; b++) begin
      chk($sformatf("max%0d.valid", b), int'(beat.valid), 1);
      chk($sformatf("max%0d.row", b), int'(beat.row_idx), b / 15);
      chk($sformatf("max%0d.col", b), int'(beat.col_idx), b % 15);
      chk($sformatf("max%0d.last", b), int'(beat.last), (b == 224) ? 1 : 0);
      step();
    end
    chk_all("max_done", 1, 0, 14, 14, 0, 1);
    step();
    chk_all("max_idle", 0, 0, 14, 14, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
